// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-approach intersection sequencer with pedestrian cut-short and night flashing
module traffic_light_ctrl #(
  parameter int CNT_W       = 8,
  parameter int GREEN_T     = 50,
  parameter int YELLOW_T    = 5,
  parameter int ALLRED_T    = 2,
  parameter int MIN_GREEN_T = 10,
  parameter int FLASH_T     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       night,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       ped_walk,
  output logic [2:0] phase
);
  localparam logic [2:0] MAIN_G = 3'd0;
  localparam logic [2:0] MAIN_Y = 3'd1;
  localparam logic [2:0] RED_A  = 3'd2;
  localparam logic [2:0] SIDE_G = 3'd3;
  localparam logic [2:0] SIDE_Y = 3'd4;
  localparam logic [2:0] RED_B  = 3'd5;
  localparam logic [2:0] FLASH  = 3'd6;
  localparam logic [CNT_W-1:0] G_END = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] R_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] M_END = CNT_W'(MIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] F_END = CNT_W'(FLASH_T - 1);
  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (CNT_W < 1 || GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || MIN_GREEN_T < 1 || FLASH_T < 1 ||
      GREEN_T >= CNT_LIM || YELLOW_T >= CNT_LIM || ALLRED_T >= CNT_LIM ||
      MIN_GREEN_T >= CNT_LIM || FLASH_T >= CNT_LIM || MIN_GREEN_T > GREEN_T) begin : g_bad_param
    $error("traffic_light_ctrl: illegal duration parameters");
  end

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic             blk;
  logic             ped_pend;

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RED_B;
    else       state <= state_nx;

  // phase counter, night blink bit and pending pedestrian request
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt      <= '0;
      blk      <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      cnt      <= (state_nx != state) ? '0 : !tick ? cnt : (state == FLASH && cnt == F_END) ? '0 : cnt + 1'b1;
      blk      <= (state_nx != FLASH) ? 1'b0 : (state == FLASH && tick && cnt == F_END) ? ~blk : blk;
      ped_pend <= (state_nx == SIDE_G && state != SIDE_G) ? 1'b0 : ped_pend | ped_req;
    end

  // next-state: a phase ends on the tick that completes its duration; night only checked leaving all-red
  always_comb begin
    state_nx = state;
    case (state)
      MAIN_G:  if (tick && (cnt == G_END || (ped_pend && cnt >= M_END))) state_nx = MAIN_Y;
      MAIN_Y:  if (tick && cnt == Y_END) state_nx = RED_A;
      RED_A:   if (tick && cnt == R_END) state_nx = night ? FLASH : SIDE_G;
      SIDE_G:  if (tick && cnt == G_END) state_nx = SIDE_Y;
      SIDE_Y:  if (tick && cnt == Y_END) state_nx = RED_B;
      RED_B:   if (tick && cnt == R_END) state_nx = night ? FLASH : MAIN_G;
      FLASH:   if (tick && !night) state_nx = RED_B;
      default: state_nx = RED_B;
    endcase
  end

  // Moore lamp decode from the registered state only
  always_comb begin
    main_g   = state == MAIN_G;
    main_y   = state == MAIN_Y || (state == FLASH && blk);
    main_r   = state inside {RED_A, RED_B, SIDE_G, SIDE_Y};
    side_g   = state == SIDE_G;
    side_y   = state == SIDE_Y || (state == FLASH && blk);
    side_r   = state inside {RED_A, RED_B, MAIN_G, MAIN_Y};
    ped_walk = state == SIDE_G;
    phase    = state;
  end
endmodule
